// File: rtl/alu_mem_pkg.sv
// Shared types and constants for the ALU operand-memory responder.
package alu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ADR_AN = 1'b0;
  localparam logic ADR_MN = 1'b1;
  localparam logic RD     = 1'b0;
  localparam logic WR     = 1'b1;

  localparam int ALU_MEM_WIDTH = 256;

  // Counter width able to hold LAT-1 for any legal LAT.
  function automatic int cnt_w(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_mem_lat_cnt.sv
// Loadable down-counter timing the wait between request acceptance and response.
module alu_mem_lat_cnt
  import alu_mem_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = cnt_w(LAT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CW'(LAT - 1);
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/alu_mem_responder.sv
// Memory-side responder for the ALU An/Mn operand words, one request at a time.
// Optional preload port set enabled by defining ALU_MEM_PRELOAD_EN.
module alu_mem_responder
  import alu_mem_pkg::*;
#(
  parameter int WIDTH = ALU_MEM_WIDTH,
  parameter int LAT   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req,
  input  logic             rdwr,
  input  logic             adr,
  input  logic [WIDTH-1:0] WD,
`ifdef ALU_MEM_PRELOAD_EN
  input  logic             ld,
  input  logic             ld_adr,
  input  logic [WIDTH-1:0] ld_data,
`endif
  output logic [WIDTH-1:0] MD,
  output logic             suc,
  output logic             busy
);

  state_e                  state_q, state_d;
  logic                    rdwr_q, rdwr_d;
  logic                    adr_q, adr_d;
  logic [WIDTH-1:0]        wd_q, wd_d;
  logic [WIDTH-1:0]        md_q, md_d;
  logic                    suc_q, suc_d;
  logic [1:0][WIDTH-1:0]   mem_q, mem_d;
  logic                    commit;
  logic                    cnt_zero;

  alu_mem_lat_cnt #(.LAT(LAT)) u_lat_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .load ((state_q == IDLE) && req),
    .en   (state_q == WAIT),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    rdwr_d  = rdwr_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    md_d    = md_q;
    suc_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        rdwr_d  = rdwr;
        adr_d   = adr;
        wd_d    = WD;
        state_d = WAIT;
      end
      WAIT: if (cnt_zero) begin
        state_d = RESP;
        suc_d   = 1'b1;
        if (rdwr_q == RD) md_d = mem_q[adr_q];
        else              commit = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Preload is applied first so a same-edge ALU write takes precedence.
  always_comb begin
    mem_d = mem_q;
`ifdef ALU_MEM_PRELOAD_EN
    if (ld) mem_d[ld_adr] = ld_data;
`endif
    if (commit) mem_d[adr_q] = wd_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rdwr_q  <= RD;
      adr_q   <= ADR_AN;
      wd_q    <= '0;
      md_q    <= '0;
      suc_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      rdwr_q  <= rdwr_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      md_q    <= md_d;
      suc_q   <= suc_d;
      mem_q   <= mem_d;
    end
  end

  assign MD   = md_q;
  assign suc  = suc_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_mem_responder.sv
// Directed bench for alu_mem_responder (LAT=4); preload cases when ALU_MEM_PRELOAD_EN is defined.
module tb_alu_mem_responder;
  import alu_mem_pkg::*;

  localparam int W = 256;
  localparam int L = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req = 1'b0, rdwr = 1'b0, adr = 1'b0;
  logic [W-1:0] WD = '0;
  logic [W-1:0] MD;
  logic         suc, busy;
`ifdef ALU_MEM_PRELOAD_EN
  logic         ld = 1'b0, ld_adr = 1'b0;
  logic [W-1:0] ld_data = '0;
`endif

  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  alu_mem_responder #(.WIDTH(W), .LAT(L)) dut (
    .CLK(CLK), .RST(RST), .req(req), .rdwr(rdwr), .adr(adr), .WD(WD),
`ifdef ALU_MEM_PRELOAD_EN
    .ld(ld), .ld_adr(ld_adr), .ld_data(ld_data),
`endif
    .MD(MD), .suc(suc), .busy(busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One transaction; suc/busy sampled after E0..E0+L+1 and compared as bit patterns.
  // inj=1: spurious write request (An, WD=5) pulsed during WAIT.
  // inj=2: preload Mn=3 on the commit edge.
  task automatic txn(input string tag, input logic rw, input logic a,
                     input logic [W-1:0] d, input int inj);
    logic [31:0] sp, bp;
    sp = '0; bp = '0;
    req = 1'b1; rdwr = rw; adr = a; WD = d;
    step();
    req = 1'b0;
    sp[0] = suc; bp[0] = busy;
    for (int i = 1; i <= L + 1; i++) begin
      if (inj == 1 && i == 2) begin req = 1'b1; rdwr = WR; adr = ADR_AN; WD = W'(5); end
      if (inj == 1 && i == 3) req = 1'b0;
`ifdef ALU_MEM_PRELOAD_EN
      if (inj == 2 && i == L) begin ld = 1'b1; ld_adr = ADR_MN; ld_data = W'(3); end
`endif
      step();
`ifdef ALU_MEM_PRELOAD_EN
      ld = 1'b0;
`endif
      sp[i] = suc; bp[i] = busy;
    end
    chk({tag, "_suc"}, W'(sp), W'(32'h0000_0010));
    chk({tag, "_busy"}, W'(bp), W'(32'h0000_001f));
  endtask

  initial begin
    logic [W-1:0] beef;
    logic         seen;
    beef = {8{32'hDEADBEEF}};

    // reset and idle
    step(); step();
    chk("rst_md", MD, '0);
    chk("rst_busy", W'(busy), '0);
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_md", MD, '0);
      chk("idle_suc", W'(suc), '0);
      chk("idle_busy", W'(busy), '0);
    end

    // write then immediately read back
    txn("wr_an_beef", WR, ADR_AN, beef, 0);
    chk("wr_md_unchanged", MD, '0);
    txn("rd_an_beef", RD, ADR_AN, '0, 0);
    chk("rd_an_beef_md", MD, beef);

    // address separation
    txn("wr_an1", WR, ADR_AN, W'(1), 0);
    txn("wr_mn2", WR, ADR_MN, W'(2), 0);
    txn("rd_mn", RD, ADR_MN, '0, 0);
    chk("rd_mn_md", MD, W'(2));
    txn("rd_an", RD, ADR_AN, '0, 0);
    chk("rd_an_md", MD, W'(1));
    txn("wr_mn33", WR, ADR_MN, W'(8'h33), 0);
    chk("wr_mn_md_hold", MD, W'(1));
    txn("rd_mn33", RD, ADR_MN, '0, 0);
    chk("rd_mn33_md", MD, W'(8'h33));

    // requests and WD changes ignored while busy
    txn("rd_mn_inj", RD, ADR_MN, '0, 1);
    chk("rd_mn_inj_md", MD, W'(8'h33));
    txn("rd_an_after_inj", RD, ADR_AN, '0, 0);
    chk("an_not_overwritten", MD, W'(1));
    txn("wr_an11_inj", WR, ADR_AN, W'(8'h11), 1);
    txn("rd_an11", RD, ADR_AN, '0, 0);
    chk("latched_wd_written", MD, W'(8'h11));

    // reset in the middle of a write
    req = 1'b1; rdwr = WR; adr = ADR_MN; WD = W'(7);
    step();
    req = 1'b0;
    step(); step();
    RST = 1'b1;
    #1;
    chk("mid_rst_md", MD, '0);
    chk("mid_rst_busy", W'(busy), '0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) RST = 1'b0;
      step();
      seen = seen | suc;
    end
    chk("mid_rst_no_suc", W'(seen), '0);
    txn("rd_mn_after_rst", RD, ADR_MN, '0, 0);
    chk("mn_cleared", MD, '0);
    txn("wr_an_after_rst", WR, ADR_AN, W'(8'h44), 0);
    txn("rd_an_after_rst", RD, ADR_AN, '0, 0);
    chk("an_after_rst", MD, W'(8'h44));

`ifdef ALU_MEM_PRELOAD_EN
    ld = 1'b1; ld_adr = ADR_MN; ld_data = W'(9);
    step();
    ld = 1'b0;
    chk("ld_md_untouched", MD, W'(8'h44));
    chk("ld_busy", W'(busy), '0);
    txn("rd_mn_ld", RD, ADR_MN, '0, 0);
    chk("ld_mn9", MD, W'(9));
    txn("wr_mn8_ld", WR, ADR_MN, W'(8), 2);
    txn("rd_mn8", RD, ADR_MN, '0, 0);
    chk("alu_write_wins", MD, W'(8));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
